// File: rtl/clk_ce_sequencer_pkg.sv
// Shared types and defaults for the clock-enable sequencer.
// Holds the FSM state enum, default ratios and a divider config check.
package clk_ce_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK,
    STABILIZE,
    RUN
  } state_t;

  localparam int CPU_NUM_DEF     = 2;
  localparam int CPU_DEN_DEF     = 23;
  localparam int VID_NUM_DEF     = 1;
  localparam int VID_DEN_DEF     = 6;
  localparam int LOCK_CYCLES_DEF = 1024;
  localparam int ACC_W_DEF       = 8;

  // True when acc+NUM can never overflow ACC_W bits.
  function automatic bit acc_w_ok(
    input int num,
    input int den,
    input int acc_w
  );
    longint lim;
    if (acc_w < 1 || acc_w > 31) return 1'b0;
    lim = longint'(1) << acc_w;
    return (num >= 1) && (num < den) &&
           (lim > longint'(den + num - 1));
  endfunction

endpackage

// File: rtl/clk_ce_sequencer_frac_ce_div.sv
// Fractional clock-enable divider: emits NUM pulses per DEN clocks.
// Ports: clk, clr (sync clear), hold (freeze), ce (registered pulse).
module frac_ce_div #(
  parameter int NUM   = 1,
  parameter int DEN   = 6,
  parameter int ACC_W = 8
) (
  input  logic clk,
  input  logic clr,
  input  logic hold,
  output logic ce
);

  logic [ACC_W-1:0] acc_q, acc_d, sum;
  logic             ce_q, ce_d;

  always_comb begin
    sum   = acc_q + ACC_W'(NUM);
    acc_d = acc_q;
    ce_d  = 1'b0;
    if (clr) begin
      acc_d = '0;
    end else if (!hold) begin
      if (sum >= ACC_W'(DEN)) begin
        acc_d = sum - ACC_W'(DEN);
        ce_d  = 1'b1;
      end else begin
        acc_d = sum;
      end
    end
  end

  always_ff @(posedge clk) begin
    acc_q <= acc_d;
    ce_q  <= ce_d;
  end

  assign ce = ce_q;

endmodule

// File: rtl/clk_ce_sequencer.sv
// PLL lock qualifier and CPU/video clock-enable generator on clk_sys.
// Ports: clk_sys, reset, pll_locked, [pause if CE_PAUSE_EN],
// rst_core, ready, ce_cpu, ce_vid, lock_lost.
module clk_ce_sequencer
  import clk_ce_pkg::*;
#(
  parameter int CPU_NUM     = CPU_NUM_DEF,
  parameter int CPU_DEN     = CPU_DEN_DEF,
  parameter int VID_NUM     = VID_NUM_DEF,
  parameter int VID_DEN     = VID_DEN_DEF,
  parameter int LOCK_CYCLES = LOCK_CYCLES_DEF,
  parameter int ACC_W       = ACC_W_DEF
) (
  input  logic clk_sys,
  input  logic reset,
  input  logic pll_locked,
`ifdef CE_PAUSE_EN
  input  logic pause,
`endif
  output logic rst_core,
  output logic ready,
  output logic ce_cpu,
  output logic ce_vid,
  output logic lock_lost
);

  localparam logic [15:0] CNT_LAST = 16'(LOCK_CYCLES - 1);

  if (!acc_w_ok(CPU_NUM, CPU_DEN, ACC_W) ||
      !acc_w_ok(VID_NUM, VID_DEN, ACC_W) ||
      LOCK_CYCLES < 1 || LOCK_CYCLES > 65535) begin : g_bad_cfg
    $error("clk_ce_sequencer: bad parameters");
  end

  logic        sync1_q, lk_s_q;
  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        lost_q, lost_d;
  logic        run, clr, hold_cpu;
  logic        cpu_ce, vid_ce;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      sync1_q <= 1'b0;
      lk_s_q  <= 1'b0;
      state_q <= WAIT_LOCK;
      cnt_q   <= '0;
      lost_q  <= 1'b0;
    end else begin
      sync1_q <= pll_locked;
      lk_s_q  <= sync1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lost_q  <= lost_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lost_d  = lost_q;
    unique case (state_q)
      WAIT_LOCK: begin
        if (lk_s_q) begin
          state_d = STABILIZE;
          cnt_d   = '0;
        end
      end
      STABILIZE: begin
        if (!lk_s_q) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = RUN;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      RUN: begin
        if (!lk_s_q) begin
          state_d = WAIT_LOCK;
          lost_d  = 1'b1;
        end
      end
      default: state_d = WAIT_LOCK;
    endcase
  end

  assign run = (state_q == RUN);
  assign clr = reset | ~run;

`ifdef CE_PAUSE_EN
  assign hold_cpu = pause;
`else
  assign hold_cpu = 1'b0;
`endif

  frac_ce_div #(
    .NUM   (CPU_NUM),
    .DEN   (CPU_DEN),
    .ACC_W (ACC_W)
  ) u_cpu (
    .clk  (clk_sys),
    .clr  (clr),
    .hold (hold_cpu),
    .ce   (cpu_ce)
  );

  frac_ce_div #(
    .NUM   (VID_NUM),
    .DEN   (VID_DEN),
    .ACC_W (ACC_W)
  ) u_vid (
    .clk  (clk_sys),
    .clr  (clr),
    .hold (1'b0),
    .ce   (vid_ce)
  );

  // The registered pulse from the last RUN edge is masked once we leave RUN.
  assign ce_cpu    = cpu_ce & run;
  assign ce_vid    = vid_ce & run;
  assign rst_core  = ~run;
  assign ready     = run;
  assign lock_lost = lost_q;

endmodule

// File: tb/tb_clk_ce_sequencer.sv
// Directed bench for clk_ce_sequencer (LOCK_CYCLES=16).
// Pause scenario is built only when CE_PAUSE_EN is defined.
module tb_clk_ce_sequencer;

  logic clk_sys = 1'b0;
  logic reset, pll_locked, pause;
  logic rst_core, ready, ce_cpu, ce_vid, lock_lost;

  int checks = 0;
  int errors = 0;

  always #5 clk_sys = ~clk_sys;

  clk_ce_sequencer #(
    .LOCK_CYCLES (16)
  ) dut (
    .clk_sys    (clk_sys),
    .reset      (reset),
    .pll_locked (pll_locked),
`ifdef CE_PAUSE_EN
    .pause      (pause),
`endif
    .rst_core   (rst_core),
    .ready      (ready),
    .ce_cpu     (ce_cpu),
    .ce_vid     (ce_vid),
    .lock_lost  (lock_lost)
  );

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  // First step is the edge that samples the new pll_locked level;
  // then count further edges until ready.
  task automatic wait_ready(input string tag, input int exp);
    int k;
    k = 0;
    step(1);
    while (!ready && k < 100) begin
      step(1);
      k++;
    end
    chk(tag, k, exp);
  endtask

  int n_cpu, n_vid, f_cpu, f_vid, n_bad;

  initial begin
    reset      = 1'b1;
    pll_locked = 1'b0;
    pause      = 1'b0;
    step(4);
    chk("rst_rst_core", rst_core, 1);
    chk("rst_ready", ready, 0);
    chk("rst_ce", ce_cpu | ce_vid, 0);
    chk("rst_lost", lock_lost, 0);

    // No lock: stay in reset, no pulses.
    reset = 1'b0;
    n_bad = 0;
    for (int i = 0; i < 200; i++) begin
      step(1);
      n_bad += int'(ce_cpu | ce_vid | ready);
    end
    chk("nolock_pulses", n_bad, 0);
    chk("nolock_rst_core", rst_core, 1);

    // Lock: 2 sync + 16 stabilise cycles.
    pll_locked = 1'b1;
    wait_ready("lock_latency", 18);
    chk("lock_rst_core", rst_core, 0);

    // Cycles 1..230 of RUN.
    n_cpu = 0; n_vid = 0; f_cpu = -1; f_vid = -1;
    for (int c = 1; c <= 230; c++) begin
      step(1);
      if (ce_cpu) begin
        n_cpu++;
        if (f_cpu < 0) f_cpu = c;
      end
      if (ce_vid) begin
        n_vid++;
        if (f_vid < 0) f_vid = c;
      end
    end
    chk("run_cpu_count", n_cpu, 20);
    chk("run_vid_count", n_vid, 38);
    chk("run_cpu_first", f_cpu, 12);
    chk("run_vid_first", f_vid, 6);

    // Lock loss in RUN.
    pll_locked = 1'b0;
    step(2);
    chk("loss_still_ready", ready, 1);
    step(1);
    chk("loss_rst_core", rst_core, 1);
    chk("loss_ce", ce_cpu | ce_vid, 0);
    chk("loss_lost", lock_lost, 1);
    n_bad = 0;
    for (int i = 0; i < 30; i++) begin
      step(1);
      n_bad += int'(ce_cpu | ce_vid);
    end
    chk("loss_no_ce", n_bad, 0);

    // Relock: phase restarts, sticky flag stays.
    pll_locked = 1'b1;
    wait_ready("relock_latency", 18);
    f_cpu = -1; f_vid = -1;
    for (int c = 1; c <= 12; c++) begin
      step(1);
      if (ce_cpu && f_cpu < 0) f_cpu = c;
      if (ce_vid && f_vid < 0) f_vid = c;
    end
    chk("relock_cpu_first", f_cpu, 12);
    chk("relock_vid_first", f_vid, 6);
    chk("relock_lost", lock_lost, 1);

`ifdef CE_PAUSE_EN
    // Pause sampled on edges 18..67; CPU acc=11 frozen, 6 edges remain.
    f_cpu = -1; n_vid = 0;
    for (int c = 13; c <= 80; c++) begin
      step(1);
      if (ce_cpu && f_cpu < 0) f_cpu = c;
      if (ce_vid && c <= 72) n_vid++;
      if (c == 17) pause = 1'b1;
      if (c == 67) pause = 1'b0;
    end
    chk("pause_cpu_next", f_cpu, 73);
    chk("pause_vid_count", n_vid, 10);
`endif

    // Reset from RUN clears everything on one edge.
    reset = 1'b1;
    step(1);
    chk("rrun_ready", ready, 0);
    chk("rrun_lost", lock_lost, 0);
    reset      = 1'b0;
    pll_locked = 1'b0;
    step(5);

    // One-cycle dropout while stabilising forces a full recount.
    pll_locked = 1'b1;
    step(10);
    chk("drop_not_ready", ready, 0);
    pll_locked = 1'b0;
    step(1);
    pll_locked = 1'b1;
    wait_ready("drop_recount", 18);
    chk("drop_lost", lock_lost, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
